// File: rtl/snake_mover.sv
// Body register and motion engine for one snake: on each tick the head steps in the
// committed direction, the body shifts, growth is applied, and wall/self hits end the run.
module snake_mover #(
    parameter int max_len         = 16,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 4,
    parameter int width           = 32,
    parameter int height          = 24,
    parameter int init_x          = 16,
    parameter int init_y          = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         tick,
    input  logic [1:0]                   dir_in,
    input  logic                         dir_valid,
    input  logic                         grow,
    output logic [max_len*num_len-1:0]   snake,
    output logic [num_len-1:0]           snake_head,
    output logic [max_len_bit_len-1:0]   len_m1,
    output logic                         alive,
    output logic                         dead
);

    localparam int x_bits = $clog2(width);
    localparam int y_bits = num_len - x_bits;
    localparam logic [num_len-1:0] empty_pos = '1;
    localparam logic [num_len-1:0] init_pos  = num_len'(init_y * width + init_x);
    localparam logic [max_len_bit_len-1:0] len_max_m1 = max_len_bit_len'(max_len - 1);

    localparam logic [1:0] dir_up    = 2'd0;
    localparam logic [1:0] dir_down  = 2'd1;
    localparam logic [1:0] dir_left  = 2'd2;
    localparam logic [1:0] dir_right = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [num_len-1:0]         seg_q [max_len];
    logic [num_len-1:0]         seg_d [max_len];
    logic [max_len_bit_len-1:0] len_m1_q, len_m1_d;
    logic [1:0]                 dir_q, dir_d;
    logic [1:0]                 pend_dir_q, pend_dir_d;
    logic                       grow_pend_q, grow_pend_d;

    logic                       dir_ok;
    logic [1:0]                 step_dir;
    logic                       growing;
    logic [x_bits-1:0]          cur_x;
    logic [y_bits-1:0]          cur_y;
    logic [num_len-1:0]         head_nx;
    logic                       wall_hit;
    logic                       self_hit;

    always_comb begin
        // A request in the same cycle as a tick still counts as "before the tick".
        dir_ok   = dir_valid && (dir_in != (dir_q ^ 2'b01));
        step_dir = dir_ok ? dir_in : pend_dir_q;
        growing  = (grow_pend_q || grow) && (len_m1_q != len_max_m1);
        cur_x    = seg_q[0][x_bits-1:0];
        cur_y    = seg_q[0][num_len-1:x_bits];

        wall_hit = 1'b0;
        head_nx  = seg_q[0];
        case (step_dir)
            dir_up: begin
                wall_hit = (cur_y == '0);
                head_nx  = seg_q[0] - num_len'(width);
            end
            dir_down: begin
                wall_hit = (cur_y == y_bits'(height - 1));
                head_nx  = seg_q[0] + num_len'(width);
            end
            dir_left: begin
                wall_hit = (cur_x == '0);
                head_nx  = seg_q[0] - num_len'(1);
            end
            default: begin
                wall_hit = (cur_x == x_bits'(width - 1));
                head_nx  = seg_q[0] + num_len'(1);
            end
        endcase

        // The tail vacates its cell this tick unless the snake is growing.
        self_hit = 1'b0;
        for (int i = 0; i < max_len; i++) begin
            if ((i < int'(len_m1_q) || (growing && i == int'(len_m1_q))) &&
                seg_q[i] == head_nx) begin
                self_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        len_m1_d    = len_m1_q;
        dir_d       = dir_q;
        pend_dir_d  = pend_dir_q;
        grow_pend_d = grow_pend_q;

        if (start) begin
            state_d     = RUN;
            len_m1_d    = max_len_bit_len'(2);
            dir_d       = dir_right;
            pend_dir_d  = dir_right;
            grow_pend_d = 1'b0;
            for (int i = 0; i < max_len; i++) begin
                seg_d[i] = empty_pos;
            end
            seg_d[0] = init_pos;
            seg_d[1] = init_pos - num_len'(1);
            seg_d[2] = init_pos - num_len'(2);
        end else if (state_q == RUN) begin
            if (dir_ok) begin
                pend_dir_d = dir_in;
            end
            if (grow) begin
                grow_pend_d = 1'b1;
            end
            if (tick) begin
                dir_d       = step_dir;
                pend_dir_d  = step_dir;
                grow_pend_d = 1'b0;
                if (wall_hit || self_hit) begin
                    state_d = DEAD;
                end else begin
                    seg_d[0] = head_nx;
                    for (int i = 1; i < max_len; i++) begin
                        seg_d[i] = seg_q[i-1];
                        if (!growing && i == int'(len_m1_q) + 1) begin
                            seg_d[i] = empty_pos;
                        end
                    end
                    if (growing) begin
                        len_m1_d = len_m1_q + max_len_bit_len'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_m1_q    <= '0;
            dir_q       <= dir_right;
            pend_dir_q  <= dir_right;
            grow_pend_q <= 1'b0;
            for (int i = 0; i < max_len; i++) begin
                seg_q[i] <= empty_pos;
            end
        end else begin
            state_q     <= state_d;
            len_m1_q    <= len_m1_d;
            dir_q       <= dir_d;
            pend_dir_q  <= pend_dir_d;
            grow_pend_q <= grow_pend_d;
            for (int i = 0; i < max_len; i++) begin
                seg_q[i] <= seg_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < max_len; i++) begin
            snake[i*num_len +: num_len] = seg_q[i];
        end
    end

    assign snake_head = seg_q[0];
    assign len_m1     = len_m1_q;
    assign alive      = (state_q == RUN);
    assign dead       = (state_q == DEAD);

endmodule

// File: tb/tb_snake_mover.sv
// Directed bench for snake_mover: start, stepping, steering, growth, walls, self hits,
// length saturation and asynchronous reset, each checked against hand-computed values.
module tb_snake_mover;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         tick;
    logic [1:0]   dir_in;
    logic         dir_valid;
    logic         grow;
    logic [159:0] snake;
    logic [9:0]   snake_head;
    logic [3:0]   len_m1;
    logic         alive;
    logic         dead;

    int total;
    int bad;

    snake_mover dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tick       (tick),
        .dir_in     (dir_in),
        .dir_valid  (dir_valid),
        .grow       (grow),
        .snake      (snake),
        .snake_head (snake_head),
        .len_m1     (len_m1),
        .alive      (alive),
        .dead       (dead)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] seg(input int i);
        return snake[i*10 +: 10];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // one clock cycle with the given inputs held across the rising edge
    task automatic cyc(input logic st, input logic tk, input logic gr,
                       input logic dv, input logic [1:0] d);
        @(negedge clk);
        start     = st;
        tick      = tk;
        grow      = gr;
        dir_valid = dv;
        dir_in    = d;
        @(posedge clk);
        #1;
        start     = 1'b0;
        tick      = 1'b0;
        grow      = 1'b0;
        dir_valid = 1'b0;
        dir_in    = 2'd0;
    endtask

    task automatic do_start();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic do_tick();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic do_dir(input logic [1:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic do_grow_tick();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        tick      = 1'b0;
        grow      = 1'b0;
        dir_valid = 1'b0;
        dir_in    = 2'd0;
        #12;
        rst_n = 1'b1;

        check("rst_head", snake_head, 1023);
        check("rst_seg5", seg(5), 1023);
        check("rst_len", len_m1, 0);
        check("rst_alive", alive, 0);
        check("rst_dead", dead, 0);

        do_tick();
        check("idle_tick_head", snake_head, 1023);

        do_start();
        check("start_head", snake_head, 400);
        check("start_seg1", seg(1), 399);
        check("start_seg2", seg(2), 398);
        check("start_seg3", seg(3), 1023);
        check("start_seg15", seg(15), 1023);
        check("start_len", len_m1, 2);
        check("start_alive", alive, 1);
        check("start_dead", dead, 0);

        do_tick();
        check("tick1_head", snake_head, 401);
        check("tick1_seg1", seg(1), 400);
        check("tick1_seg2", seg(2), 399);
        check("tick1_seg3", seg(3), 1023);

        do_dir(2'd2);
        do_tick();
        check("reverse_ignored_head", snake_head, 402);

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        do_dir(2'd1);
        do_tick();
        check("grow_down_head", snake_head, 434);
        check("grow_down_len", len_m1, 3);
        check("grow_down_seg1", seg(1), 402);
        check("grow_down_seg3", seg(3), 400);
        check("grow_down_seg4", seg(4), 1023);

        do_start();
        do_dir(2'd1);
        do_grow_tick();
        check("coinc_grow_head", snake_head, 432);
        check("coinc_grow_len", len_m1, 3);
        check("coinc_grow_seg3", seg(3), 398);
        do_tick();
        check("grow_cleared_head", snake_head, 464);
        check("grow_cleared_len", len_m1, 3);
        check("grow_cleared_seg3", seg(3), 399);
        check("grow_cleared_seg4", seg(4), 1023);
        do_dir(2'd2);
        do_dir(2'd3);
        do_tick();
        check("last_dir_wins_head", snake_head, 465);

        // right wall
        do_start();
        for (int i = 0; i < 15; i++) do_tick();
        check("right_edge_head", snake_head, 415);
        check("right_edge_alive", alive, 1);
        do_tick();
        check("right_wall_dead", dead, 1);
        check("right_wall_alive", alive, 0);
        check("right_wall_head", snake_head, 415);
        check("right_wall_seg1", seg(1), 414);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        do_grow_tick();
        check("dead_frozen_head", snake_head, 415);
        check("dead_frozen_len", len_m1, 2);
        check("dead_frozen_dead", dead, 1);
        do_start();
        check("restart_head", snake_head, 400);
        check("restart_alive", alive, 1);
        check("restart_dead", dead, 0);

        // top wall: y from 12 to 0 in 12 ticks, the 13th hits
        do_dir(2'd0);
        for (int i = 0; i < 12; i++) do_tick();
        check("top_edge_head", snake_head, 16);
        check("top_edge_alive", alive, 1);
        do_tick();
        check("top_wall_dead", dead, 1);
        check("top_wall_head", snake_head, 16);

        // stepping into the vacating tail is legal
        do_start();
        do_grow_tick();
        do_dir(2'd0);
        do_tick();
        do_dir(2'd2);
        do_tick();
        check("tail_setup_head", snake_head, 368);
        do_dir(2'd1);
        do_tick();
        check("tail_chase_alive", alive, 1);
        check("tail_chase_head", snake_head, 400);
        check("tail_chase_seg3", seg(3), 401);

        // self collision
        do_start();
        do_grow_tick();
        do_grow_tick();
        check("self_setup_len", len_m1, 4);
        check("self_setup_head", snake_head, 402);
        do_dir(2'd0);
        do_tick();
        do_dir(2'd2);
        do_tick();
        check("self_setup_head2", snake_head, 369);
        do_dir(2'd1);
        do_tick();
        check("self_hit_dead", dead, 1);
        check("self_hit_alive", alive, 0);
        check("self_hit_head", snake_head, 369);
        check("self_hit_len", len_m1, 4);

        // growth saturates at 16 segments
        do_start();
        for (int i = 0; i < 13; i++) do_grow_tick();
        check("full_head", snake_head, 413);
        check("full_len", len_m1, 15);
        check("full_seg15", seg(15), 398);
        do_grow_tick();
        check("sat_head", snake_head, 414);
        check("sat_len", len_m1, 15);
        check("sat_seg15", seg(15), 399);
        check("sat_alive", alive, 1);

        // asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_head", snake_head, 1023);
        check("async_rst_len", len_m1, 0);
        check("async_rst_alive", alive, 0);
        check("async_rst_seg15", seg(15), 1023);
        #2;
        rst_n = 1'b1;
        do_tick();
        check("post_rst_tick_head", snake_head, 1023);
        check("post_rst_tick_alive", alive, 0);
        do_start();
        check("post_rst_start_head", snake_head, 400);
        check("post_rst_start_alive", alive, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
